fp_input_conditioner: RTL and testbench
=======================================

Name: fp_input_conditioner

Overview:
- Conditions the raw Nexys4 board inputs (13 slide switches, 5 push buttons) before they reach the front panel logic in Top.
- Per input: 2-flop synchronizer, then a debouncer.
- Buttons additionally produce one-cycle press/release pulses and optional auto-repeat, so the front panel can step addresses/data on held up/down buttons.
- Sits directly upstream of Front_Panel; its outputs replace the raw sw/btn* signals.

Parameters:
- SW_WIDTH, 13, number of switch inputs.
- NUM_BTN, 5, number of buttons; index 0=btnc, 1=btnu, 2=btnd, 3=btnl, 4=btnr.
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synced input must differ from its stable value before the stable value changes (10 ms @ 100 MHz); legal range >=1.
- REPEAT_DELAY, 50000000, cycles from the initial press pulse to the first auto-repeat pulse; legal range >=1.
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses; legal range >=1.
- REPEAT_MASK, 5'b00110, per-button auto-repeat enable (btnu, btnd by default).

Ports:
- clock  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- sw_raw  in  SW_WIDTH  raw slide switches, asynchronous to clock.
- btn_raw  in  NUM_BTN  raw buttons, active-high, asynchronous to clock.
- sw_level  out  SW_WIDTH  debounced switch values.
- sw_changed  out  1  one-cycle pulse when any sw_level bit changes.
- btn_level  out  NUM_BTN  debounced button levels.
- btn_press  out  NUM_BTN  one-cycle press pulse, including auto-repeat pulses.
- btn_release  out  NUM_BTN  one-cycle release pulse.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is clock, reset port is resetN.
- Reset: all sync flops, stable values, counters and timers cleared to 0. All outputs are 0 during reset and on the first cycle after release. FSMs go to IDLE. Reset mid-count discards the partial count; reset while a button is held forces IDLE, and that button needs a fresh debounced rise to press again.
- Sync: 2 flops per input; sync output s.
- Debounce, per bit, with counter width $clog2(DEBOUNCE_CYCLES+1):
  - If s == stable, counter <= 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1: stable <= s and counter <= 0.
  - Otherwise counter <= counter+1.
  - A single glitch cycle of s == stable restarts the count.
  - Latency from raw edge to level change: 2 + DEBOUNCE_CYCLES cycles.
- sw_changed: registered; high in exactly the first cycle a new sw_level value is visible. Multiple bits changing in one cycle give a single pulse.
- Button FSM, per button (IDLE, HOLD, REPEAT), with timer width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1):
  - IDLE: on stable 0->1, btn_press high in the same cycle btn_level first reads 1. If the mask bit is set, load timer=REPEAT_DELAY-1 and go to HOLD; if clear, stay in HOLD with the timer frozen.
  - HOLD (mask set): timer decrements. At timer==0 with level 1: press pulse, load REPEAT_PERIOD-1, go to REPEAT.
  - REPEAT: same as HOLD, reloading REPEAT_PERIOD-1 on each pulse.
  - Result: presses at t0, t0+REPEAT_DELAY, then every +REPEAT_PERIOD.
  - Any state, stable 1->0: btn_release high in the first cycle btn_level reads 0, timer cleared, go to IDLE.
  - Release and a repeat expiry in the same cycle: release wins, no press.
  - btn_press and btn_release are never high together for the same button.
- Buttons are fully independent; simultaneous presses on several buttons pulse in the same cycle.

Test Plan:
(sim params DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
- Reset: resetN=0 with sw_raw=13'h1FFF, btn_raw=5'h1F -> all outputs 0. After release: sw_level=13'h1FFF at cycle 6, single sw_changed pulse at cycle 6.
- Bounce: btn_raw[0] toggles 1,0,1 on cycles 0-2, then held 1 -> btn_level[0] rises 6 cycles after the last edge; exactly one btn_press[0] pulse; btn_release[0] never pulses.
- Glitch: btn_raw[3] high for 3 cycles, then low -> btn_level, btn_press and btn_release all stay 0.
- Auto-repeat: btn_raw[1] held 30 cycles, press seen at t0 -> btn_press[1] at t0, t0+10, t0+13, t0+16, ...; on release, one btn_release[1] and no further presses.
- No repeat: btn_raw[4] (mask 0) held 40 cycles -> exactly one btn_press[4].
- Reset mid-hold: assert resetN=0 for 1 cycle during REPEAT on btn_raw[2] while the button stays held -> outputs go to 0. After reset, btn_level[2] re-rises after 6 cycles with a fresh btn_press[2], and the repeat timing restarts.

Source files
------------

// File: rtl/fp_input_conditioner.sv
// rtl/fp_input_conditioner.sv - synchronize, debounce and edge/auto-repeat conditioning of board switches and buttons
module fp_input_conditioner #(
  parameter int                  SW_WIDTH        = 13,
  parameter int                  NUM_BTN         = 5,
  parameter int                  DEBOUNCE_CYCLES = 1000000,
  parameter int                  REPEAT_DELAY    = 50000000,
  parameter int                  REPEAT_PERIOD   = 10000000,
  parameter logic [NUM_BTN-1:0]  REPEAT_MASK     = 5'b00110
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic [SW_WIDTH-1:0] sw_raw,
  input  logic [NUM_BTN-1:0]  btn_raw,
  output logic [SW_WIDTH-1:0] sw_level,
  output logic                sw_changed,
  output logic [NUM_BTN-1:0]  btn_level,
  output logic [NUM_BTN-1:0]  btn_press,
  output logic [NUM_BTN-1:0]  btn_release
);

  localparam int N    = SW_WIDTH + NUM_BTN;
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] T_DELAY  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] T_PERIOD = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  logic [N-1:0]  raw;
  logic [N-1:0]  sync1;
  logic [N-1:0]  s;
  logic [N-1:0]  stable;
  logic [N-1:0]  upd;
  logic [CW-1:0] cnt [N];

  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] btn_fall;
  state_t             state [NUM_BTN];
  logic [TW-1:0]      timer [NUM_BTN];

  assign raw = {btn_raw, sw_raw};

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

  // upd marks the cycle in which a stable bit takes its new value
  always_comb begin
    upd = '0;
    for (int i = 0; i < N; i++) begin
      upd[i] = (s[i] != stable[i]) && (cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      stable <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (s[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          stable[i] <= s[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign sw_level  = stable[SW_WIDTH-1:0];
  assign btn_level = stable[N-1:SW_WIDTH];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sw_changed <= 1'b0;
    end else begin
      sw_changed <= |upd[SW_WIDTH-1:0];
    end
  end

  assign btn_rise = upd[N-1:SW_WIDTH] & s[N-1:SW_WIDTH];
  assign btn_fall = upd[N-1:SW_WIDTH] & ~s[N-1:SW_WIDTH];

  // Press/release are registered alongside the stable update so they line up with btn_level
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      btn_press   <= '0;
      btn_release <= '0;
      for (int b = 0; b < NUM_BTN; b++) begin
        state[b] <= IDLE;
        timer[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BTN; b++) begin
        btn_press[b]   <= 1'b0;
        btn_release[b] <= 1'b0;
        if (btn_fall[b]) begin
          btn_release[b] <= 1'b1;
          timer[b]       <= '0;
          state[b]       <= IDLE;
        end else begin
          case (state[b])
            IDLE: begin
              if (btn_rise[b]) begin
                btn_press[b] <= 1'b1;
                state[b]     <= HOLD;
                timer[b]     <= REPEAT_MASK[b] ? T_DELAY : '0;
              end
            end
            HOLD, REPEAT: begin
              if (REPEAT_MASK[b]) begin
                if (timer[b] == '0) begin
                  btn_press[b] <= 1'b1;
                  timer[b]     <= T_PERIOD;
                  state[b]     <= REPEAT;
                end else begin
                  timer[b] <= timer[b] - 1'b1;
                end
              end
            end
            default: begin
              state[b] <= IDLE;
              timer[b] <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_input_conditioner.sv
// tb/tb_fp_input_conditioner.sv - randomized self-checking bench for fp_input_conditioner
module tb_fp_input_conditioner;

  localparam int SW = 13;
  localparam int NB = 5;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam logic [NB-1:0] MASK = 5'b00110;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic [SW-1:0] sw_raw = '0;
  logic [NB-1:0] btn_raw = '0;
  logic [SW-1:0] sw_level;
  logic          sw_changed;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  int checks = 0;
  int errors = 0;

  fp_input_conditioner #(
    .SW_WIDTH(SW), .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)
  ) dut (
    .clock(clock), .resetN(resetN), .sw_raw(sw_raw), .btn_raw(btn_raw),
    .sw_level(sw_level), .sw_changed(sw_changed), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clock = ~clock;

  logic [28:0] obs;
  assign obs = {sw_level, sw_changed, btn_level, btn_press, btn_release};

  // Reference model: an input's level follows its synchronized value once that value
  // has disagreed with the level for DB consecutive cycles; presses are derived from level age.
  int              cyc;
  logic [SW+NB-1:0] m_raw1, m_s, m_lvl;
  int              m_run [SW+NB];
  int              rise_cyc [NB];
  logic [28:0]     exp_v;

  function automatic void model_clear();
    cyc = 0; m_raw1 = '0; m_s = '0; m_lvl = '0; exp_v = '0;
    for (int i = 0; i < SW+NB; i++) m_run[i] = 0;
    for (int b = 0; b < NB; b++) rise_cyc[b] = 0;
  endfunction

  function automatic void model_step();
    logic [SW+NB-1:0] nl;
    logic [NB-1:0] pr, rl;
    logic swc;
    int age;
    cyc++;
    nl = m_lvl;
    for (int i = 0; i < SW+NB; i++) begin
      if (m_s[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin nl[i] = m_s[i]; m_run[i] = 0; end
      end else m_run[i] = 0;
    end
    m_s = m_raw1;
    m_raw1 = {btn_raw, sw_raw};
    swc = (nl[SW-1:0] != m_lvl[SW-1:0]);
    pr = '0; rl = '0;
    for (int b = 0; b < NB; b++) begin
      if (nl[SW+b] && !m_lvl[SW+b]) begin pr[b] = 1'b1; rise_cyc[b] = cyc; end
      else if (!nl[SW+b] && m_lvl[SW+b]) rl[b] = 1'b1;
      else if (nl[SW+b] && MASK[b]) begin
        age = cyc - rise_cyc[b];
        if (age >= RD && (age - RD) % RP == 0) pr[b] = 1'b1;
      end
    end
    m_lvl = nl;
    exp_v = {m_lvl[SW-1:0], swc, m_lvl[SW+NB-1:SW], pr, rl};
  endfunction

  task automatic tick();
    @(posedge clock);
    if (!resetN) model_clear(); else model_step();
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    int first_lvl = -1;
    int chg = 0;
    resetN = 1'b0; sw_raw = 13'h1FFF; btn_raw = 5'h1F; model_clear();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_hold got %h expected 0", obs); end
    end
    resetN = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 1) begin
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_first_cycle got %h expected 0", obs); end
      end
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset_model n=%0d got %h expected %h", n, obs, exp_v); end
      if (sw_changed) chg++;
      if (first_lvl < 0 && sw_level == 13'h1FFF) first_lvl = n;
    end
    checks++;
    if (first_lvl != 6) begin errors++; $display("FAIL reset_sw_latency got %0d expected 6", first_lvl); end
    checks++;
    if (chg != 1) begin errors++; $display("FAIL reset_sw_changed_count got %0d expected 1", chg); end
    sw_raw = '0; btn_raw = '0;
    settle(20);
  endtask

  task automatic test_bounce();
    int first_lvl = -1;
    int np = 0;
    int nr = 0;
    btn_raw[0] = 1'b1; tick();
    btn_raw[0] = 1'b0; tick();
    btn_raw[0] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL bounce_model n=%0d got %h expected %h", n, obs, exp_v); end
      if (first_lvl < 0 && btn_level[0]) first_lvl = n;
      if (btn_press[0]) np++;
      if (btn_release[0]) nr++;
    end
    checks++;
    if (first_lvl != 6) begin errors++; $display("FAIL bounce_latency got %0d expected 6", first_lvl); end
    checks++;
    if (np != 1) begin errors++; $display("FAIL bounce_press_count got %0d expected 1", np); end
    checks++;
    if (nr != 0) begin errors++; $display("FAIL bounce_release_count got %0d expected 0", nr); end
    btn_raw[0] = 1'b0;
    settle(10);
  endtask

  task automatic test_glitch();
    int act = 0;
    btn_raw[3] = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      if (n == 4) btn_raw[3] = 1'b0;
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL glitch_model n=%0d got %h expected %h", n, obs, exp_v); end
      if (btn_level[3] || btn_press[3] || btn_release[3]) act++;
    end
    checks++;
    if (act != 0) begin errors++; $display("FAIL glitch_activity got %0d expected 0", act); end
  endtask

  task automatic test_autorepeat();
    int t0 = -1;
    int rel = -1;
    int np = 0;
    int nr = 0;
    int late = 0;
    int want;
    btn_raw[1] = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      if (n == 31) btn_raw[1] = 1'b0;
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL repeat_model n=%0d got %h expected %h", n, obs, exp_v); end
      if (btn_press[1]) begin
        np++;
        if (rel >= 0) late++;
        if (t0 < 0) t0 = n;
        else begin
          checks++;
          if (!((n - t0) >= RD && ((n - t0 - RD) % RP) == 0)) begin
            errors++; $display("FAIL repeat_offset got %0d expected %0d+%0d*k", n - t0, RD, RP);
          end
        end
      end
      if (btn_release[1]) begin nr++; if (rel < 0) rel = n; end
    end
    want = 1;
    for (int o = RD; o < rel - t0; o += RP) want++;
    checks++;
    if (t0 != 6) begin errors++; $display("FAIL repeat_t0 got %0d expected 6", t0); end
    checks++;
    if (rel != 36) begin errors++; $display("FAIL repeat_release_time got %0d expected 36", rel); end
    checks++;
    if (np != want) begin errors++; $display("FAIL repeat_press_count got %0d expected %0d", np, want); end
    checks++;
    if (nr != 1 || late != 0) begin errors++; $display("FAIL repeat_release got rel=%0d late=%0d expected 1 0", nr, late); end
  endtask

  task automatic test_norepeat();
    int np = 0;
    int nr = 0;
    btn_raw[4] = 1'b1;
    for (int n = 1; n <= 55; n++) begin
      if (n == 41) btn_raw[4] = 1'b0;
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL norepeat_model n=%0d got %h expected %h", n, obs, exp_v); end
      if (btn_press[4]) np++;
      if (btn_release[4]) nr++;
    end
    checks++;
    if (np != 1 || nr != 1) begin errors++; $display("FAIL norepeat_counts got press=%0d rel=%0d expected 1 1", np, nr); end
  endtask

  task automatic test_reset_midhold();
    int first_lvl = -1;
    int p2 = -1;
    btn_raw[2] = 1'b1;
    settle(20);
    resetN = 1'b0; model_clear();
    #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL midhold_async_reset got %h expected 0", obs); end
    tick();
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL midhold_in_reset got %h expected 0", obs); end
    resetN = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL midhold_model n=%0d got %h expected %h", n, obs, exp_v); end
      if (first_lvl < 0 && btn_level[2]) first_lvl = n;
      if (btn_press[2] && n > 6 && p2 < 0) p2 = n;
    end
    checks++;
    if (first_lvl != 6) begin errors++; $display("FAIL midhold_relatch got %0d expected 6", first_lvl); end
    checks++;
    if (p2 != 16) begin errors++; $display("FAIL midhold_first_repeat got %0d expected 16", p2); end
    btn_raw[2] = 1'b0;
    settle(12);
  endtask

  task automatic test_random();
    int hold;
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 2) == 0) sw_raw = sw_raw ^ SW'($urandom_range(0, 8191));
      btn_raw = NB'($urandom_range(0, 31));
      hold = $urandom_range(1, 9);
      for (int k = 0; k < hold; k++) begin
        tick();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL random_model it=%0d got %h expected %h", it, obs, exp_v); end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_bounce();
    test_glitch();
    test_autorepeat();
    test_norepeat();
    test_reset_midhold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
